// File: rtl/stack_controller.sv
// -----------------------------------------------------------------------------
// stack_controller
//
// Multicycle control FSM for the 8-bit stack-machine datapath. It takes the
// IR opcode and the top-of-stack value, and it drives every datapath strobe.
//
// Handshake: there is no valid/ready pair. The datapath acts on each strobe
// in the same cycle the strobe is high. instr_done is a one-cycle pulse in
// the last cycle of every instruction.
//
// Optional feature (macro STACK_CTRL_PERF_EN):
//   Adds the instr_count output. This is a CNT_W-bit counter of retired
//   instructions. Reset clears it, and it wraps from all-ones to 0.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset; forces every strobe to 0
//   opcode[2:0]  IR[7:5]
//   tos          current top-of-stack (only its zero-ness is used)
//   pc_write, ir_write, mdr_en, addrSrc, mem_write, push, pop, stack_src,
//   load_a, load_b, alu_control[1:0], jump, instr_done
//                datapath control strobes
//   instr_count  retired-instruction counter (STACK_CTRL_PERF_EN only)
//   state_dbg    current FSM state, for observation
// -----------------------------------------------------------------------------
module stack_controller #(
  parameter int TOS_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       opcode,
  input  logic [TOS_W-1:0] tos,
  output logic             pc_write,
  output logic             ir_write,
  output logic             mdr_en,
  output logic             addrSrc,
  output logic             mem_write,
  output logic             push,
  output logic             pop,
  output logic             stack_src,
  output logic             load_a,
  output logic             load_b,
  output logic [1:0]       alu_control,
  output logic             jump,
  output logic             instr_done,
`ifdef STACK_CTRL_PERF_EN
  output logic [CNT_W-1:0] instr_count,
`endif
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    FETCH    = 3'd0,
    DECODE   = 3'd1,
    POP_A    = 3'd2,
    POP_B    = 3'd3,
    ALU_PUSH = 3'd4,
    MEM_RD   = 3'd5,
    PUSH_MDR = 3'd6,
    MEM_WR   = 3'd7
  } state_t;

  state_t state;
  logic   tos_zero;

  assign tos_zero  = (tos == '0);
  assign state_dbg = state;

  // State register and next-state selection.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:  state <= DECODE;
        DECODE: begin
          case (opcode)
            3'b000, 3'b001, 3'b010, 3'b011: state <= POP_A;
            3'b100:                         state <= MEM_RD;
            3'b101:                         state <= MEM_WR;
            default:                        state <= FETCH;  // jmp / jz
          endcase
        end
        // "not" has only one operand, so it skips the second pop.
        POP_A:    state <= (opcode == 3'b011) ? ALU_PUSH : POP_B;
        POP_B:    state <= ALU_PUSH;
        MEM_RD:   state <= PUSH_MDR;
        default:  state <= FETCH;  // ALU_PUSH, PUSH_MDR, MEM_WR
      endcase
    end
  end

  // Output decode. Reset overrides the decode, so an abandoned instruction
  // leaves no partial strobes behind.
  always_comb begin
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    mdr_en      = 1'b0;
    addrSrc     = 1'b0;
    mem_write   = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    stack_src   = 1'b0;
    load_a      = 1'b0;
    load_b      = 1'b0;
    alu_control = 2'b00;
    jump        = 1'b0;
    instr_done  = 1'b0;
    if (!rst) begin
      case (state)
        FETCH: begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end
        DECODE: begin
          if (opcode == 3'b110) begin
            pc_write   = 1'b1;
            jump       = 1'b1;
            instr_done = 1'b1;
          end else if (opcode == 3'b111) begin
            // jz tests TOS but does not consume it.
            pc_write   = tos_zero;
            jump       = tos_zero;
            instr_done = 1'b1;
          end
        end
        POP_A: begin
          load_a = 1'b1;
          pop    = 1'b1;
        end
        POP_B: begin
          load_b = 1'b1;
          pop    = 1'b1;
        end
        ALU_PUSH: begin
          alu_control = opcode[1:0];
          push        = 1'b1;
          instr_done  = 1'b1;
        end
        MEM_RD: begin
          addrSrc = 1'b1;
          mdr_en  = 1'b1;
        end
        PUSH_MDR: begin
          stack_src  = 1'b1;
          push       = 1'b1;
          instr_done = 1'b1;
        end
        MEM_WR: begin
          // Memory takes the TOS in this same cycle, before the pop lands.
          addrSrc    = 1'b1;
          mem_write  = 1'b1;
          pop        = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef STACK_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_count <= '0;
    end else if (instr_done) begin
      instr_count <= instr_count + 1'b1;
    end
  end
`else
  logic [CNT_W-1:0] perf_unused;
  assign perf_unused = '0;
`endif

endmodule

// File: tb/tb_stack_controller.sv
module tb_stack_controller;

  logic        clk;
  logic        rst;
  logic [2:0]  opcode;
  logic [7:0]  tos;
  logic        pc_write, ir_write, mdr_en, addrSrc, mem_write, push, pop;
  logic        stack_src, load_a, load_b, jump, instr_done;
  logic [1:0]  alu_control;
  logic [2:0]  state_dbg;
`ifdef STACK_CTRL_PERF_EN
  logic [15:0] instr_count;
  logic [15:0] exp_count;
`endif

  int n_checks;
  int n_fail;

  // Bit positions of the packed output vector.
  localparam logic [13:0] M_PCW  = 14'h2000;
  localparam logic [13:0] M_IRW  = 14'h1000;
  localparam logic [13:0] M_MDR  = 14'h0800;
  localparam logic [13:0] M_ADDR = 14'h0400;
  localparam logic [13:0] M_MEMW = 14'h0200;
  localparam logic [13:0] M_PUSH = 14'h0100;
  localparam logic [13:0] M_POP  = 14'h0080;
  localparam logic [13:0] M_SSRC = 14'h0040;
  localparam logic [13:0] M_LA   = 14'h0020;
  localparam logic [13:0] M_LB   = 14'h0010;
  localparam logic [13:0] M_JUMP = 14'h0002;
  localparam logic [13:0] M_DONE = 14'h0001;

  logic [13:0] act;
  logic [13:0] exp_q[$];

  assign act = {pc_write, ir_write, mdr_en, addrSrc, mem_write, push, pop,
                stack_src, load_a, load_b, alu_control, jump, instr_done};

  stack_controller #(.TOS_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .tos(tos),
    .pc_write(pc_write), .ir_write(ir_write), .mdr_en(mdr_en),
    .addrSrc(addrSrc), .mem_write(mem_write), .push(push), .pop(pop),
    .stack_src(stack_src), .load_a(load_a), .load_b(load_b),
    .alu_control(alu_control), .jump(jump), .instr_done(instr_done),
`ifdef STACK_CTRL_PERF_EN
    .instr_count(instr_count),
`endif
    .state_dbg(state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model. Each instruction is expanded into its expected
  // per-cycle strobe pattern, with FETCH included.
  task automatic model_instr(input logic [2:0] op, input logic [7:0] t);
    logic [13:0] alu_bits;
    alu_bits = {10'd0, op[1:0], 2'b00};
    exp_q.push_back(M_PCW | M_IRW);                    // fetch
    case (op)
      3'b000, 3'b001, 3'b010: begin
        exp_q.push_back(14'h0);                        // decode
        exp_q.push_back(M_LA | M_POP);
        exp_q.push_back(M_LB | M_POP);
        exp_q.push_back(alu_bits | M_PUSH | M_DONE);
      end
      3'b011: begin
        exp_q.push_back(14'h0);
        exp_q.push_back(M_LA | M_POP);
        exp_q.push_back(alu_bits | M_PUSH | M_DONE);
      end
      3'b100: begin
        exp_q.push_back(14'h0);
        exp_q.push_back(M_ADDR | M_MDR);
        exp_q.push_back(M_SSRC | M_PUSH | M_DONE);
      end
      3'b101: begin
        exp_q.push_back(14'h0);
        exp_q.push_back(M_ADDR | M_MEMW | M_POP | M_DONE);
      end
      3'b110: exp_q.push_back(M_PCW | M_JUMP | M_DONE);
      default: exp_q.push_back(((t == 8'h00) ? (M_PCW | M_JUMP) : 14'h0) | M_DONE);
    endcase
  endtask

  // Driver plus scoreboard. Call it at the start of a FETCH cycle, just
  // after the clock edge. On return the bench sits at the start of the next
  // instruction.
  task automatic run_instr(input logic [2:0] op, input logic [7:0] t, input string name);
    logic [13:0] e;
    model_instr(op, t);
    opcode = op;
    tos    = t;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      n_checks++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s op=%0d tos=%0h: outputs got %b want %b", name, op, t, act, e);
      end
      n_checks++;
      if (push && pop) begin
        n_fail++;
        $display("FAIL %s push_pop_overlap: got push=1 pop=1 want not both", name);
      end
      @(posedge clk);
      #1;
`ifdef STACK_CTRL_PERF_EN
      if (e[0]) exp_count = exp_count + 16'd1;
`endif
    end
`ifdef STACK_CTRL_PERF_EN
    n_checks++;
    if (instr_count !== exp_count) begin
      n_fail++;
      $display("FAIL %s instr_count: got %0d want %0d", name, instr_count, exp_count);
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; opcode = 3'b000; tos = 8'h00;
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if (act !== 14'h0) begin
        n_fail++;
        $display("FAIL reset_initial: got %b want 0", act);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
`ifdef STACK_CTRL_PERF_EN
    exp_count = 16'd0;
    n_checks++;
    if (instr_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_count: got %0d want 0", instr_count);
    end
`endif
    // Walk an add into POP_B, then reset it for two clock edges.
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    n_checks++;
    if (act !== (M_LB | M_POP)) begin
      n_fail++;
      $display("FAIL reset_pre_pop_b: got %b want %b", act, M_LB | M_POP);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (act !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_mid_pop_b: got %b want 0", act);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (act !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_second_cycle: got %b want 0", act);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if (state_dbg !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %0d want 0 (FETCH)", state_dbg);
    end
  endtask

  task automatic test_alu();
    run_instr(3'b000, 8'h11, "add");
    run_instr(3'b001, 8'h22, "sub");
    run_instr(3'b010, 8'h00, "and");
    run_instr(3'b011, 8'h33, "not");
  endtask

  task automatic test_mem();
    run_instr(3'b100, 8'h44, "push_mem");
    run_instr(3'b101, 8'h55, "pop_mem");
  endtask

  task automatic test_jump();
    run_instr(3'b111, 8'h00, "jz_taken");
    run_instr(3'b111, 8'h05, "jz_not_taken");
    run_instr(3'b111, 8'h80, "jz_msb_only");
    run_instr(3'b110, 8'h00, "jmp");
  endtask

  task automatic test_back_to_back();
    logic [2:0] op;
    logic [7:0] t;
    for (int i = 0; i < 300; i++) begin
      op = 3'($urandom_range(0, 7));
      t  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      run_instr(op, t, "random");
    end
  endtask

`ifdef STACK_CTRL_PERF_EN
  task automatic test_perf();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_count = 16'd0;
    run_instr(3'b000, 8'h01, "perf_add");
    run_instr(3'b110, 8'h01, "perf_jmp");
    run_instr(3'b101, 8'h01, "perf_pop");
    n_checks++;
    if (instr_count !== 16'd3) begin
      n_fail++;
      $display("FAIL perf_three: got %0d want 3", instr_count);
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_alu();
    test_mem();
    test_jump();
    test_back_to_back();
`ifdef STACK_CTRL_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
